alarm_tone_seq: RTL and testbench
=================================

Name: alarm_tone_seq

Overview:
Parametrised successor to the fixed 220 Hz alarm beeper. Plays a programmable looping sequence of NOTES tones, each with its own half-period divider and duration, plus rests and a snooze window. Sits between the alarm-compare logic, which drives alarm_i, and the speaker pin; the button debouncer drives snooze_i.

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz
NOTES, 4, number of sequence entries (>=1)
DIV_W, 16, width of each note half-period divider
DUR_W, 8, width of each note duration, in ticks
TICK_HZ, 100, duration tick rate; TICK_CYC = CLK_FREQ/TICK_HZ cycles per tick
SNOOZE_TICKS, 30000, snooze length in ticks (default 5 min at 100 Hz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
alarm_i  in  1  level; high = alarm active
snooze_i  in  1  single-cycle pulse; request snooze
note_div_i  in  NOTES*DIV_W  packed half-period dividers, entry k at [k*DIV_W +: DIV_W]; 0 = rest
note_dur_i  in  NOTES*DUR_W  packed durations in ticks, entry k at [k*DUR_W +: DUR_W]; 0 = skip
speaker  out  1  square-wave output
playing  out  1  high in PLAY
snoozing  out  1  high in SNOOZE
note_idx  out  $clog2(NOTES) (min 1)  current entry index

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state=IDLE, speaker=0, playing=0, snoozing=0, note_idx=0. All counters are 0.
- FSM states: IDLE, PLAY, SNOOZE. Outputs are registered.
- IDLE -> PLAY on the first cycle alarm_i=1. On entry: note_idx=0, tick prescaler=0, duration counter=0, tone counter=div[0]-1, speaker=0.
- PLAY, tone:
  - Tone counter counts down.
  - At 0 it reloads div[idx]-1, and speaker toggles if div[idx]!=0.
  - With div[idx]=0 (rest), speaker is forced to 0.
  - Half-period is exactly div[idx] cycles.
- PLAY, duration:
  - Prescaler counts 0..TICK_CYC-1; tick = (prescaler==TICK_CYC-1).
  - On tick, the duration counter increments.
  - When the duration counter reaches dur[idx]-1 and tick=1, advance: idx = idx+1, wrapping NOTES-1 -> 0. Prescaler, duration counter and tone counter are reloaded for the new entry. Speaker is forced to 0.
  - Each note therefore lasts exactly dur*TICK_CYC cycles.
- dur[idx]=0: the entry is skipped in one cycle, speaker=0. If all durations are 0, idx cycles one per clock, speaker stays 0, and there is no lockup.
- Table inputs are sampled on every note load. Changes take effect at the next note boundary, never mid-note.
- snooze_i=1 in PLAY -> SNOOZE next cycle. Speaker=0, snoozing=1, prescaler and snooze counter cleared.
- SNOOZE:
  - Counts SNOOZE_TICKS ticks.
  - On expiry with alarm_i=1 -> PLAY with the same entry behaviour as from IDLE (idx 0).
  - snooze_i during SNOOZE is ignored; the timer does not restart.
- alarm_i=0 in PLAY or SNOOZE -> IDLE next cycle, with the reset values on all outputs. This has priority over snooze_i and over note advance in the same cycle.
- snooze_i in IDLE is ignored.
- Reset mid-note or mid-snooze returns immediately to the reset values.
- Width rules:
  - Prescaler: $clog2(TICK_CYC).
  - Snooze counter: $clog2(SNOOZE_TICKS+1).
  - Tone counter: DIV_W; div=1 toggles every cycle.
  - Index increment wraps explicitly, since NOTES need not be a power of 2.

Decomposition:
- Shared package alarm_pkg holds:
  - Default tick/snooze constants.
  - State encoding enum {IDLE, PLAY, SNOOZE}.
  - Helper constants for packed table slicing.
- One sub-module, tone_divider: loadable down-counter with reload value, enable and toggle output, covering the tone counter and speaker flop.
- The FSM, prescaler and duration/snooze counters stay in alarm_tone_seq.

Test Plan:
Sim parameters: CLK_FREQ=1000, TICK_HZ=100 (TICK_CYC=10), NOTES=3, SNOOZE_TICKS=4.
- div={5,0,2}, dur={2,1,3}, raise alarm_i: playing=1 next cycle. Speaker toggles every 5 cycles for 20 cycles, stays 0 for 10 cycles, toggles every 2 cycles for 30 cycles, then note_idx wraps to 0 at cycle 60.
- dur={2,0,1}, div={3,3,3}: idx goes 0 -> 1 -> 2, with entry 1 held exactly 1 cycle and speaker=0 during it. Entry 2 lasts 10 cycles.
- Pulse snooze_i in note 0: speaker=0, snoozing=1 for 40 cycles. Then PLAY restarts at idx 0 with a fresh 5-cycle half-period.
- Drop alarm_i in the same cycle as snooze_i and as a note-boundary tick: next cycle is IDLE with all outputs 0.
- Assert rst asynchronously mid-note (no clock edge): speaker, playing and note_idx are 0 immediately. After release with alarm_i=1, sequence restarts from idx 0.
- Change div[1] from 4 to 6 during note 0: note 1 plays with half-period 6; note 0 is unaffected.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm tone sequencer.
package alarm_pkg;

  localparam int DEF_CLK_FREQ     = 12_000_000;
  localparam int DEF_TICK_HZ      = 100;
  localparam int DEF_SNOOZE_TICKS = 30000;
  localparam int DEF_NOTES        = 4;
  localparam int DEF_DIV_W        = 16;
  localparam int DEF_DUR_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of entry k inside a packed table of w-bit entries.
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/alarm_tone_divider.sv
// Loadable half-period down-counter driving the speaker flop; a zero divider is a rest.
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] run_div,
  output logic             speaker
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (load) begin
      cnt     <= load_div - DIV_W'(1);
      speaker <= 1'b0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt     <= run_div - DIV_W'(1);
        speaker <= (run_div != '0) ? ~speaker : 1'b0;
      end else begin
        cnt <= cnt - DIV_W'(1);
        if (run_div == '0) speaker <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alarm_tone_seq.sv
// Looping multi-note alarm tone player with rests, skips and a snooze window.
//   state     | meaning
//   ST_IDLE   | silent, waiting for alarm_i
//   ST_PLAY   | stepping through the note table, speaker active
//   ST_SNOOZE | silent for SNOOZE_TICKS ticks, then replays from entry 0
module alarm_tone_seq
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int NOTES        = DEF_NOTES,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DUR_W        = DEF_DUR_W,
  parameter int TICK_HZ      = DEF_TICK_HZ,
  parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
  localparam int IDX_W       = cnt_width(NOTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alarm_i,
  input  logic                   snooze_i,
  input  logic [NOTES*DIV_W-1:0] note_div_i,
  input  logic [NOTES*DUR_W-1:0] note_dur_i,
  output logic                   speaker,
  output logic                   playing,
  output logic                   snoozing,
  output logic [IDX_W-1:0]       note_idx
);

  localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
  localparam int PRE_W    = cnt_width(TICK_CYC);
  localparam int SNZ_W    = cnt_width(SNOOZE_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'((SNOOZE_TICKS > 0) ? SNOOZE_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES - 1);

  logic [DIV_W-1:0] div_tab [NOTES];
  logic [DUR_W-1:0] dur_tab [NOTES];

  for (genvar k = 0; k < NOTES; k++) begin : g_tab
    assign div_tab[k] = note_div_i[slice_lsb(k, DIV_W) +: DIV_W];
    assign dur_tab[k] = note_dur_i[slice_lsb(k, DUR_W) +: DUR_W];
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [PRE_W-1:0] presc;
  logic [DUR_W-1:0] dur_cnt;
  logic [SNZ_W-1:0] snz_cnt;
  logic [DIV_W-1:0] cur_div;
  logic [DUR_W-1:0] cur_dur;

  logic tick, note_end;
  logic go_idle, start_play, go_snooze, adv, ld_note;
  logic tone_clr, tone_en;
  logic [DIV_W-1:0] next_div;

  assign tick     = (presc == PRE_LAST);
  // A zero-duration entry ends in the same cycle it is loaded.
  assign note_end = (cur_dur == '0) || (tick && (dur_cnt == cur_dur - DUR_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    go_idle    = 1'b0;
    start_play = 1'b0;
    go_snooze  = 1'b0;
    adv        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alarm_i) begin
          state_n    = ST_PLAY;
          start_play = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!alarm_i) begin
          state_n = ST_IDLE;
          go_idle = 1'b1;
        end else if (snooze_i) begin
          state_n   = ST_SNOOZE;
          go_snooze = 1'b1;
        end else if (note_end) begin
          adv = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_i) begin
          state_n = ST_IDLE;
          go_idle = 1'b1;
        end else if (tick && (snz_cnt == SNZ_LAST)) begin
          state_n    = ST_PLAY;
          start_play = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        go_idle = 1'b1;
      end
    endcase

    idx_n = note_idx;
    if (go_idle || start_play) idx_n = '0;
    else if (adv)              idx_n = (note_idx == IDX_LAST) ? '0 : note_idx + IDX_W'(1);
  end

  assign ld_note  = start_play | adv;
  assign next_div = div_tab[idx_n];
  assign tone_clr = go_idle | go_snooze;
  assign tone_en  = (state == ST_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_idx <= '0;
      playing  <= 1'b0;
      snoozing <= 1'b0;
      presc    <= '0;
      dur_cnt  <= '0;
      snz_cnt  <= '0;
      cur_div  <= '0;
      cur_dur  <= '0;
    end else begin
      note_idx <= idx_n;
      playing  <= (state_n == ST_PLAY);
      snoozing <= (state_n == ST_SNOOZE);

      // Table entries are latched only at note load, so edits never land mid-note.
      if (ld_note) begin
        cur_div <= next_div;
        cur_dur <= dur_tab[idx_n];
      end else if (go_idle) begin
        cur_div <= '0;
        cur_dur <= '0;
      end

      if (go_idle || go_snooze || ld_note || (state == ST_IDLE) || tick) presc <= '0;
      else                                                                presc <= presc + PRE_W'(1);

      if (go_idle || go_snooze || ld_note)  dur_cnt <= '0;
      else if ((state == ST_PLAY) && tick)  dur_cnt <= dur_cnt + DUR_W'(1);

      if ((state != ST_SNOOZE) || go_idle || start_play) snz_cnt <= '0;
      else if (tick)                                     snz_cnt <= snz_cnt + SNZ_W'(1);
    end
  end

  tone_divider #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk      (clk),
    .rst      (rst),
    .clr      (tone_clr),
    .load     (ld_note),
    .en       (tone_en),
    .load_div (next_div),
    .run_div  (cur_div),
    .speaker  (speaker)
  );

endmodule

// File: tb/tb_alarm_tone_seq.sv
// Directed bench for alarm_tone_seq: note timing, rests, skips, snooze, priority and async reset.
module tb_alarm_tone_seq;

  logic        clk, rst, alarm_i, snooze_i;
  logic [47:0] note_div_i;
  logic [23:0] note_dur_i;
  logic        speaker, playing, snoozing;
  logic [1:0]  note_idx;

  int checks   = 0;
  int failures = 0;
  int exp_spk, exp_idx;

  alarm_tone_seq #(
    .CLK_FREQ(1000), .NOTES(3), .DIV_W(16), .DUR_W(8), .TICK_HZ(100), .SNOOZE_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .alarm_i(alarm_i), .snooze_i(snooze_i),
    .note_div_i(note_div_i), .note_dur_i(note_dur_i),
    .speaker(speaker), .playing(playing), .snoozing(snoozing), .note_idx(note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_speaker"},  32'(speaker),  32'd0);
    check({tag, "_playing"},  32'(playing),  32'd0);
    check({tag, "_snoozing"}, 32'(snoozing), 32'd0);
    check({tag, "_idx"},      32'(note_idx), 32'd0);
  endtask

  initial begin
    rst = 1'b0; alarm_i = 1'b0; snooze_i = 1'b0;
    note_div_i = {16'd2, 16'd0, 16'd5};
    note_dur_i = {8'd3, 8'd1, 8'd2};
    #1 rst = 1'b1;
    #1;
    check_idle("reset");
    step(); step();
    rst = 1'b0;
    step();

    snooze_i = 1'b1; step(); snooze_i = 1'b0;
    check_idle("idle_snooze");

    // div {5,0,2}, dur {2,1,3}: 20 cycles tone, 10 rest, 30 tone, wrap at 60
    alarm_i = 1'b1; step();
    for (int c = 0; c <= 60; c++) begin
      exp_spk = (c < 20) ? (c / 5) % 2 : (c < 30) ? 0 : (c < 60) ? ((c - 30) / 2) % 2 : 0;
      exp_idx = (c < 20) ? 0 : (c < 30) ? 1 : (c < 60) ? 2 : 0;
      check($sformatf("seq_playing_c%0d", c), 32'(playing), 32'd1);
      check($sformatf("seq_speaker_c%0d", c), 32'(speaker), 32'(exp_spk));
      check($sformatf("seq_idx_c%0d", c), 32'(note_idx), 32'(exp_idx));
      step();
    end

    alarm_i = 1'b0; step();
    check_idle("alarm_drop");

    // dur {2,0,1}, div {3,3,3}: entry 1 held one silent cycle, entry 2 ten cycles
    note_div_i = {16'd3, 16'd3, 16'd3};
    note_dur_i = {8'd1, 8'd0, 8'd2};
    alarm_i = 1'b1; step();
    for (int c = 0; c <= 31; c++) begin
      exp_idx = (c < 20) ? 0 : (c == 20) ? 1 : (c <= 30) ? 2 : 0;
      exp_spk = (c < 20) ? (c / 3) % 2 : (c == 20) ? 0 : (c <= 30) ? ((c - 21) / 3) % 2 : 0;
      check($sformatf("skip_idx_c%0d", c), 32'(note_idx), 32'(exp_idx));
      check($sformatf("skip_speaker_c%0d", c), 32'(speaker), 32'(exp_spk));
      step();
    end

    // snooze in note 0 with a repeat pulse that must be ignored
    alarm_i = 1'b0; step();
    note_div_i = {16'd2, 16'd0, 16'd5};
    note_dur_i = {8'd3, 8'd1, 8'd2};
    alarm_i = 1'b1; step();
    step(); step(); step();
    check("pre_snooze_idx", 32'(note_idx), 32'd0);
    snooze_i = 1'b1; step(); snooze_i = 1'b0;
    for (int s = 0; s < 40; s++) begin
      check($sformatf("snz_snoozing_s%0d", s), 32'(snoozing), 32'd1);
      check($sformatf("snz_playing_s%0d", s), 32'(playing), 32'd0);
      check($sformatf("snz_speaker_s%0d", s), 32'(speaker), 32'd0);
      snooze_i = (s == 10);
      step();
    end
    snooze_i = 1'b0;
    for (int p = 0; p < 10; p++) begin
      check($sformatf("resume_playing_p%0d", p), 32'(playing), 32'd1);
      check($sformatf("resume_snoozing_p%0d", p), 32'(snoozing), 32'd0);
      check($sformatf("resume_idx_p%0d", p), 32'(note_idx), 32'd0);
      check($sformatf("resume_speaker_p%0d", p), 32'(speaker), 32'((p / 5) % 2));
      step();
    end

    // alarm drop coinciding with snooze request and note-boundary tick
    for (int i = 0; i < 9; i++) step();
    check("boundary_pre_idx", 32'(note_idx), 32'd0);
    alarm_i = 1'b0; snooze_i = 1'b1; step(); snooze_i = 1'b0;
    check_idle("priority");

    // asynchronous reset in the middle of note 2
    alarm_i = 1'b1; step();
    for (int i = 0; i < 32; i++) step();
    check("pre_rst_idx", 32'(note_idx), 32'd2);
    check("pre_rst_speaker", 32'(speaker), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    #1 rst = 1'b0;
    step();
    check("post_rst_playing", 32'(playing), 32'd1);
    check("post_rst_idx", 32'(note_idx), 32'd0);
    check("post_rst_speaker", 32'(speaker), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("post_rst_speaker_p5", 32'(speaker), 32'd1);

    // table edit mid-note: div[1] 4->6 and div[0] 5->3 during note 0
    alarm_i = 1'b0; step();
    note_div_i = {16'd2, 16'd4, 16'd5};
    note_dur_i = {8'd1, 8'd2, 8'd2};
    alarm_i = 1'b1; step();
    for (int c = 0; c < 40; c++) begin
      exp_idx = (c < 20) ? 0 : 1;
      exp_spk = (c < 20) ? (c / 5) % 2 : ((c - 20) / 6) % 2;
      check($sformatf("edit_idx_c%0d", c), 32'(note_idx), 32'(exp_idx));
      check($sformatf("edit_speaker_c%0d", c), 32'(speaker), 32'(exp_spk));
      if (c == 3) note_div_i = {16'd2, 16'd6, 16'd3};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
